// File: rtl/pc_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer_pkg
// Description : Shared op-code constants and helpers for the program-counter
//               sequencer and its return-address stack.
// Contents    : PC_OP_WIDTH, PC_OP_* op codes, pc_op_t, ras_cnt_width().
// Revision    : 1.0 - initial release
// ============================================================================
package pc_sequencer_pkg;

  localparam int PC_OP_WIDTH = 3;

  typedef logic [PC_OP_WIDTH-1:0] pc_op_t;

  localparam pc_op_t PC_OP_HOLD = 3'd0;
  localparam pc_op_t PC_OP_INC  = 3'd1;
  localparam pc_op_t PC_OP_JMP  = 3'd2;
  localparam pc_op_t PC_OP_BRR  = 3'd3;
  localparam pc_op_t PC_OP_CALL = 3'd4;
  localparam pc_op_t PC_OP_RET  = 3'd5;

  // Occupancy counter needs one extra bit so that "full" (== depth) is
  // distinguishable from "empty" (== 0).
  function automatic int ras_cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pc_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer_if
// Description : Decoder <-> sequencer bus: op/operand/stall toward the
//               sequencer, fetch address and RAS status back.
// Ports       : i_stall, i_op, i_data (decoder -> sequencer)
//               o_pc, o_ras_full, o_ras_empty, o_ras_ovf, o_ras_unf
//               (sequencer -> decoder / instruction memory)
// Modports    : master (decoder side), slave (sequencer side)
// Revision    : 1.0 - initial release
// ============================================================================
interface pc_sequencer_if
  import pc_sequencer_pkg::*;
#(
  parameter int PC_WIDTH = 16
);

  logic                   i_stall;
  logic [PC_OP_WIDTH-1:0] i_op;
  logic [PC_WIDTH-1:0]    i_data;
  logic [PC_WIDTH-1:0]    o_pc;
  logic                   o_ras_full;
  logic                   o_ras_empty;
  logic                   o_ras_ovf;
  logic                   o_ras_unf;

  modport master (
    output i_stall, i_op, i_data,
    input  o_pc, o_ras_full, o_ras_empty, o_ras_ovf, o_ras_unf
  );

  modport slave (
    input  i_stall, i_op, i_data,
    output o_pc, o_ras_full, o_ras_empty, o_ras_ovf, o_ras_unf
  );

endinterface
`default_nettype wire

// File: rtl/pc_ras_stack.sv
`default_nettype none
// ============================================================================
// Module      : pc_ras_stack
// Description : Return-address stack (LIFO) with occupancy counter,
//               full/empty decode and registered overflow/underflow pulses.
//               Optional macro PC_RAS_CIRCULAR_EN: push while full overwrites
//               the oldest entry instead of being discarded.
// Ports       : clk, rst_n (sync, active-low)
//               push_i/push_data_i - push request and return address
//               pop_i              - pop request
//               top_o              - most recently pushed entry
//               full_o, empty_o    - decoded from the registered counter
//               ovf_o, unf_o       - one-cycle pulses after push-full /
//                                    pop-empty requests
// Revision    : 1.0 - initial release
// ============================================================================
module pc_ras_stack
  import pc_sequencer_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4  // >= 2, power of 2
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             push_i,
  input  wire logic [WIDTH-1:0] push_data_i,
  input  wire logic             pop_i,
  output logic      [WIDTH-1:0] top_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  ovf_o,
  output logic                  unf_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = ras_cnt_width(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  // ptr_q is the next write slot; it wraps modulo DEPTH, so the top of
  // stack is always ptr_q-1 in both the discarding and circular variants.
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, unf_q;
  logic             push_ok, pop_ok;

  assign full_o  = (cnt_q == DEPTH_CNT);
  assign empty_o = (cnt_q == '0);
  assign top_o   = mem_q[ptr_q - PTR_W'(1)];
  assign ovf_o   = ovf_q;
  assign unf_o   = unf_q;

`ifdef PC_RAS_CIRCULAR_EN
  assign push_ok = push_i;
`else
  assign push_ok = push_i & ~full_o;
`endif
  assign pop_ok = pop_i & ~empty_o;

  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (push_ok) begin
      ptr_d = ptr_q + PTR_W'(1);
      // An overwriting push leaves occupancy pinned at DEPTH.
      if (!full_o) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (pop_ok) begin
      ptr_d = ptr_q - PTR_W'(1);
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      ovf_q <= push_i & full_o;
      unf_q <= pop_i & empty_o;
    end
  end

  // Entry storage carries no reset; contents are meaningless while empty.
  always_ff @(posedge clk) begin
    if (rst_n && push_ok) begin
      mem_q[ptr_q] <= push_data_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Program-counter sequencer: hold, increment, absolute jump,
//               signed relative branch, call and return via an internal
//               return-address stack. All PC arithmetic wraps modulo
//               2^PC_WIDTH; o_pc is registered with no bypass from i_data.
//               Optional macro PC_RAS_CIRCULAR_EN (see pc_ras_stack).
// Ports       : clk, rst_n (sync, active-low)
//               seq_if (pc_sequencer_if.slave):
//                 i_stall, i_op, i_data -> in
//                 o_pc, o_ras_full, o_ras_empty, o_ras_ovf, o_ras_unf -> out
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int                PC_WIDTH  = 16,
  parameter int                RAS_DEPTH = 4,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  pc_sequencer_if.slave    seq_if
);

  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] pc_inc;
  logic [PC_WIDTH-1:0] ras_top;
  logic                ras_push, ras_pop;
  logic                ras_full, ras_empty;
  logic                ras_ovf, ras_unf;

  assign pc_inc = pc_q + PC_WIDTH'(1);

  always_comb begin
    pc_d     = pc_q;
    ras_push = 1'b0;
    ras_pop  = 1'b0;
    if (!seq_if.i_stall) begin
      case (seq_if.i_op)
        PC_OP_HOLD: pc_d = pc_q;
        PC_OP_INC:  pc_d = pc_inc;
        PC_OP_JMP:  pc_d = seq_if.i_data;
        // Operand is already PC_WIDTH wide, so modular addition is the
        // sign-extended relative branch.
        PC_OP_BRR:  pc_d = pc_q + seq_if.i_data;
        PC_OP_CALL: begin
          pc_d     = seq_if.i_data;
          ras_push = 1'b1;
        end
        PC_OP_RET: begin
          // Return on an empty stack degrades to a plain advance.
          pc_d    = ras_empty ? pc_inc : ras_top;
          ras_pop = 1'b1;
        end
        default:    pc_d = pc_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  pc_ras_stack #(
    .WIDTH (PC_WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (ras_push),
    .push_data_i (pc_inc),
    .pop_i       (ras_pop),
    .top_o       (ras_top),
    .full_o      (ras_full),
    .empty_o     (ras_empty),
    .ovf_o       (ras_ovf),
    .unf_o       (ras_unf)
  );

  assign seq_if.o_pc        = pc_q;
  assign seq_if.o_ras_full  = ras_full;
  assign seq_if.o_ras_empty = ras_empty;
  assign seq_if.o_ras_ovf   = ras_ovf;
  assign seq_if.o_ras_unf   = ras_unf;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_sequencer
// Description : Directed, table-driven bench for pc_sequencer
//               (PC_WIDTH=16, RAS_DEPTH=4, RESET_PC=0). Expected values
//               follow PC_RAS_CIRCULAR_EN when that macro is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

  localparam logic [2:0] HOLD = 3'd0;
  localparam logic [2:0] INC  = 3'd1;
  localparam logic [2:0] JMP  = 3'd2;
  localparam logic [2:0] BRR  = 3'd3;
  localparam logic [2:0] CALL = 3'd4;
  localparam logic [2:0] RET  = 3'd5;

  typedef struct {
    logic        rst_n;
    logic        stall;
    logic [2:0]  op;
    logic [15:0] data;
    logic [15:0] pc;
    logic        full;
    logic        empty;
    logic        ovf;
    logic        unf;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_total = 0;
  int   n_bad   = 0;
  vec_t vecs[$];

  pc_sequencer_if #(.PC_WIDTH(16)) bus ();

  pc_sequencer #(
    .PC_WIDTH  (16),
    .RAS_DEPTH (4),
    .RESET_PC  (16'h0000)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .seq_if (bus)
  );

  always #5 clk = ~clk;

  task automatic add(input logic r, input logic s, input logic [2:0] op,
                     input logic [15:0] d, input logic [15:0] pc,
                     input logic f, input logic e, input logic o,
                     input logic u);
    vec_t v;
    v.rst_n = r; v.stall = s; v.op = op; v.data = d; v.pc = pc;
    v.full = f; v.empty = e; v.ovf = o; v.unf = u;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx,
                       input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  // Drive one op, let one rising edge pass, then sample away from the edge.
  task automatic step(input logic r, input logic s, input logic [2:0] op,
                      input logic [15:0] d);
    rst_n       = r;
    bus.i_stall = s;
    bus.i_op    = op;
    bus.i_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input int idx,
                           input logic [15:0] pc, input logic f,
                           input logic e, input logic o, input logic u);
    check({tag, ".pc"},    idx, bus.o_pc, pc);
    check({tag, ".full"},  idx, {15'd0, bus.o_ras_full},  {15'd0, f});
    check({tag, ".empty"}, idx, {15'd0, bus.o_ras_empty}, {15'd0, e});
    check({tag, ".ovf"},   idx, {15'd0, bus.o_ras_ovf},   {15'd0, o});
    check({tag, ".unf"},   idx, {15'd0, bus.o_ras_unf},   {15'd0, u});
  endtask

  initial begin
    rst_n       = 1'b0;
    bus.i_stall = 1'b0;
    bus.i_op    = HOLD;
    bus.i_data  = '0;

    //   rst  stl op    data      pc       F  E  O  U
    add(1'b0, 0, HOLD, 16'h0000, 16'h0000, 0, 1, 0, 0);
    add(1'b1, 0, INC,  16'h0000, 16'h0001, 0, 1, 0, 0);
    add(1'b1, 0, INC,  16'h0000, 16'h0002, 0, 1, 0, 0);
    add(1'b1, 0, INC,  16'h0000, 16'h0003, 0, 1, 0, 0);
    add(1'b1, 0, JMP,  16'hFFFE, 16'hFFFE, 0, 1, 0, 0);
    add(1'b1, 0, INC,  16'h0000, 16'hFFFF, 0, 1, 0, 0);
    add(1'b1, 0, INC,  16'h0000, 16'h0000, 0, 1, 0, 0);
    add(1'b1, 0, JMP,  16'h0010, 16'h0010, 0, 1, 0, 0);
    add(1'b1, 0, BRR,  16'hFFFC, 16'h000C, 0, 1, 0, 0);
    add(1'b1, 0, BRR,  16'h0004, 16'h0010, 0, 1, 0, 0);
    add(1'b1, 0, BRR,  16'h0000, 16'h0010, 0, 1, 0, 0);
    add(1'b1, 0, 3'd6, 16'h1234, 16'h0010, 0, 1, 0, 0);
    add(1'b1, 0, 3'd7, 16'h1234, 16'h0010, 0, 1, 0, 0);
    add(1'b1, 0, JMP,  16'h0020, 16'h0020, 0, 1, 0, 0);
    add(1'b1, 0, CALL, 16'h0100, 16'h0100, 0, 0, 0, 0);
    add(1'b1, 0, CALL, 16'h0200, 16'h0200, 0, 0, 0, 0);
    add(1'b1, 0, RET,  16'h0000, 16'h0101, 0, 0, 0, 0);
    add(1'b1, 0, RET,  16'h0000, 16'h0021, 0, 1, 0, 0);
    add(1'b1, 0, RET,  16'h0000, 16'h0022, 0, 1, 0, 1);
    add(1'b1, 0, HOLD, 16'h0000, 16'h0022, 0, 1, 0, 0);
    add(1'b1, 0, CALL, 16'h0300, 16'h0300, 0, 0, 0, 0);
    add(1'b1, 1, CALL, 16'h0400, 16'h0300, 0, 0, 0, 0);
    add(1'b1, 1, RET,  16'h0000, 16'h0300, 0, 0, 0, 0);
    add(1'b1, 0, RET,  16'h0000, 16'h0023, 0, 1, 0, 0);
    add(1'b1, 0, JMP,  16'h1000, 16'h1000, 0, 1, 0, 0);
    add(1'b1, 0, CALL, 16'h2000, 16'h2000, 0, 0, 0, 0);
    add(1'b1, 0, CALL, 16'h3000, 16'h3000, 0, 0, 0, 0);
    add(1'b1, 0, CALL, 16'h4000, 16'h4000, 0, 0, 0, 0);
    add(1'b1, 0, CALL, 16'h5000, 16'h5000, 1, 0, 0, 0);
    add(1'b1, 0, CALL, 16'h6000, 16'h6000, 1, 0, 1, 0);
    add(1'b1, 1, CALL, 16'h7000, 16'h6000, 1, 0, 0, 0);
`ifdef PC_RAS_CIRCULAR_EN
    add(1'b1, 0, RET,  16'h0000, 16'h5001, 0, 0, 0, 0);
    add(1'b1, 0, RET,  16'h0000, 16'h4001, 0, 0, 0, 0);
    add(1'b1, 0, RET,  16'h0000, 16'h3001, 0, 0, 0, 0);
    add(1'b1, 0, RET,  16'h0000, 16'h2001, 0, 1, 0, 0);
    add(1'b1, 0, RET,  16'h0000, 16'h2002, 0, 1, 0, 1);
`else
    add(1'b1, 0, RET,  16'h0000, 16'h4001, 0, 0, 0, 0);
    add(1'b1, 0, RET,  16'h0000, 16'h3001, 0, 0, 0, 0);
    add(1'b1, 0, RET,  16'h0000, 16'h2001, 0, 0, 0, 0);
    add(1'b1, 0, RET,  16'h0000, 16'h1001, 0, 1, 0, 0);
    add(1'b1, 0, RET,  16'h0000, 16'h1002, 0, 1, 0, 1);
`endif
    add(1'b1, 0, CALL, 16'h0500, 16'h0500, 0, 0, 0, 0);
    add(1'b1, 0, CALL, 16'h0600, 16'h0600, 0, 0, 0, 0);
    add(1'b0, 0, CALL, 16'h0700, 16'h0000, 0, 1, 0, 0);
    add(1'b1, 0, RET,  16'h0000, 16'h0001, 0, 1, 0, 1);

    foreach (vecs[i]) begin
      step(vecs[i].rst_n, vecs[i].stall, vecs[i].op, vecs[i].data);
      check_all("vec", i, vecs[i].pc, vecs[i].full, vecs[i].empty,
                vecs[i].ovf, vecs[i].unf);
    end

    // Stall held over several cycles with a CALL pending, then released.
    step(1'b0, 0, HOLD, 16'h0000);
    check_all("seq_rst", 0, 16'h0000, 0, 1, 0, 0);
    step(1'b1, 0, JMP,  16'h0040);
    step(1'b1, 0, CALL, 16'h0080);
    check_all("seq_call", 0, 16'h0080, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1, CALL, 16'h0090);
      check_all("seq_stall", k, 16'h0080, 0, 0, 0, 0);
    end
    step(1'b1, 0, RET, 16'h0000);
    check_all("seq_ret", 0, 16'h0041, 0, 1, 0, 0);
    // Call followed directly by return.
    step(1'b1, 0, CALL, 16'h00A0);
    check_all("seq_bb_call", 0, 16'h00A0, 0, 0, 0, 0);
    step(1'b1, 0, RET, 16'h0000);
    check_all("seq_bb_ret", 0, 16'h0042, 0, 1, 0, 0);
    // Overflow pulse is exactly one cycle wide.
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 0, CALL, 16'h0800);
    end
    check_all("seq_ovf", 0, 16'h0800, 1, 0, 1, 0);
    step(1'b1, 0, HOLD, 16'h0000);
    check_all("seq_ovf_end", 0, 16'h0800, 1, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
